// File: rtl/align_shifter_pipe.sv
// Two-stage pipelined barrel shifter for mantissa alignment/normalisation.
// Stage A resolves the high shift-amount bits, stage B the low bits and drives the outputs.
// Sticky mode accumulates the OR of every bit shifted out across both stages.
module align_shifter_pipe #(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned SPLIT   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               sticky_out
);

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;
  localparam logic [1:0] MODE_STK = 2'b11;

  logic               a_valid;
  logic [WIDTH-1:0]   a_data;
  logic               a_sticky;
  logic [SPLIT-1:0]   a_lo;
  logic [1:0]         a_mode;

  logic               b_load;
  logic               a_load;

  logic [SHAMT_W-1:0] amt_hi_c;
  logic [WIDTH-1:0]   mask_hi_c;
  logic [WIDTH-1:0]   a_data_c;
  logic               a_sticky_c;

  logic [WIDTH-1:0]   mask_lo_c;
  logic [WIDTH-1:0]   b_data_c;
  logic               b_sticky_c;

  // Handshake: no skid buffer, so in_ready follows out_ready combinationally.
  assign b_load   = !out_valid || out_ready;
  assign a_load   = !a_valid || b_load;
  assign in_ready = a_load;

  // Stage A shift by the high-order amount bits (multiples of 2^SPLIT).
  always_comb begin
    amt_hi_c   = {shamt[SHAMT_W-1:SPLIT], {SPLIT{1'b0}}};
    mask_hi_c  = ~({WIDTH{1'b1}} << amt_hi_c);
    a_data_c   = data_in >> amt_hi_c;
    a_sticky_c = 1'b0;
    case (mode)
      MODE_ASR: a_data_c = $unsigned($signed(data_in) >>> amt_hi_c);
      MODE_LSL: a_data_c = data_in << amt_hi_c;
      MODE_STK: a_sticky_c = |(data_in & mask_hi_c);
      default:  a_data_c = data_in >> amt_hi_c;
    endcase
  end

  // Stage B shift by the low-order amount bits; sign of ASR data is preserved by stage A.
  always_comb begin
    mask_lo_c  = ~({WIDTH{1'b1}} << a_lo);
    b_data_c   = a_data >> a_lo;
    b_sticky_c = 1'b0;
    case (a_mode)
      MODE_ASR: b_data_c = $unsigned($signed(a_data) >>> a_lo);
      MODE_LSL: b_data_c = a_data << a_lo;
      MODE_STK: b_sticky_c = a_sticky | (|(a_data & mask_lo_c));
      default:  b_data_c = a_data >> a_lo;
    endcase
  end

  // Stage A register; a bubble clears only the valid bit and holds the payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid  <= 1'b0;
      a_data   <= '0;
      a_sticky <= 1'b0;
      a_lo     <= '0;
      a_mode   <= MODE_LSR;
    end else if (a_load) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_data   <= a_data_c;
        a_sticky <= a_sticky_c;
        a_lo     <= shamt[SPLIT-1:0];
        a_mode   <= mode;
      end
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      sticky_out <= 1'b0;
    end else if (b_load) begin
      out_valid <= a_valid;
      if (a_valid) begin
        data_out   <= b_data_c;
        sticky_out <= b_sticky_c;
      end
    end
  end

endmodule

// File: tb/tb_align_shifter_pipe.sv
// Scoreboard bench for align_shifter_pipe: directed cases, stall, reset and random traffic.
module tb_align_shifter_pipe;

  localparam int unsigned WIDTH   = 24;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned SPLIT   = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   data_in = '0;
  logic [SHAMT_W-1:0] shamt = '0;
  logic [1:0]         mode = 2'b00;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [WIDTH-1:0]   data_out;
  logic               sticky_out;

  align_shifter_pipe #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .SPLIT(SPLIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shamt(shamt), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .sticky_out(sticky_out)
  );

  always #5 clk = ~clk;

  logic [WIDTH:0] q[$];
  logic [WIDTH:0] exp_v;
  logic [WIDTH:0] held_val;
  int             n_tests = 0;
  int             n_fail = 0;
  int             occ;
  bit             chk_en = 1'b0;
  bit             held = 1'b0;
  bit             done = 1'b0;

  // Reference: each result bit chosen by its source position, sticky as OR of dropped LSBs.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] d,
                                           input logic [SHAMT_W-1:0] s,
                                           input logic [1:0] m);
    logic [WIDTH-1:0] r;
    logic st;
    int sa;
    sa = int'(s);
    r = '0;
    st = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (m == 2'b10) r[i] = (i >= sa) ? d[i-sa] : 1'b0;
      else r[i] = (i + sa < int'(WIDTH)) ? d[i+sa] : ((m == 2'b01) ? d[WIDTH-1] : 1'b0);
      if (m == 2'b11 && i < sa) st = st | d[i];
    end
    return {st, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: handshakes are sampled mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (chk_en) begin
      occ = q.size();
      check("in_ready", 32'(in_ready), 32'(!(occ == 2 && !out_ready)));
      if (held) check("stall_hold", 32'({out_valid, sticky_out, data_out}), 32'({1'b1, held_val}));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'(0));
        end else begin
          exp_v = q.pop_front();
          check("data_out", 32'(data_out), 32'(exp_v[WIDTH-1:0]));
          check("sticky_out", 32'(sticky_out), 32'(exp_v[WIDTH]));
        end
      end
      if (in_valid && in_ready) q.push_back(model(data_in, shamt, mode));
      held = out_valid && !out_ready;
      held_val = {sticky_out, data_out};
    end
  end

  // Present one transaction until accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s, input logic [1:0] m);
    logic ok;
    int n;
    in_valid = 1'b1;
    data_in = d;
    shamt = s;
    mode = m;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("send_timeout", 32'(ok), 32'(1));
    in_valid = 1'b0;
    data_in = WIDTH'($urandom);
    shamt = SHAMT_W'($urandom);
    mode = 2'($urandom);
  endtask

  task automatic wait_idle();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Two-edge latency: not valid after the accepting edge, valid after the next.
  task automatic lat_check(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s, input logic [1:0] m);
    send(d, s, m);
    check("lat_edge1", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;
    check("lat_edge2", 32'(out_valid), 32'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_data_out", 32'(data_out), 32'(0));
    check("rst_sticky", 32'(sticky_out), 32'(0));
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));

    // Directed corner cases
    out_ready = 1'b1;
    lat_check(24'h800000, 5'd23, 2'b00);
    send(24'h000007, 5'd2, 2'b11);
    send(24'h000004, 5'd2, 2'b11);
    send(24'h800000, 5'd4, 2'b01);
    send(24'h800000, 5'd31, 2'b01);
    send(24'h000001, 5'd31, 2'b11);
    send(24'h000003, 5'd22, 2'b10);
    send(24'h000003, 5'd23, 2'b10);
    send(24'hA5A5A5, 5'd0, 2'b11);
    send(24'hFFFFFF, 5'd24, 2'b10);
    send(24'h7FFFFF, 5'd24, 2'b01);
    send(24'h123456, 5'd8, 2'b11);
    wait_idle();

    // Back-to-back stream with a 3-cycle stall
    fork
      begin
        for (int i = 0; i < 8; i++) send(WIDTH'($urandom), SHAMT_W'($urandom), 2'($urandom));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset with both stages occupied
    out_ready = 1'b0;
    send(24'h00F00F, 5'd3, 2'b11);
    send(24'h0F0F0F, 5'd5, 2'b00);
    @(negedge clk);
    check("full_out_valid", 32'(out_valid), 32'(1));
    check("full_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_data_out", 32'(data_out), 32'(0));
    check("midrst_sticky", 32'(sticky_out), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    held = 1'b0;
    chk_en = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("postrst_no_valid", 32'(out_valid), 32'(0));
    lat_check(24'hC00001, 5'd1, 2'b01);
    wait_idle();

    // Random traffic with random back-pressure and input bubbles
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          if ($urandom_range(0, 7) == 0) send(WIDTH'($urandom), '0, 2'($urandom));
          else send(WIDTH'($urandom), SHAMT_W'($urandom), 2'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
      end
    join

    // Drain and confirm nothing lost
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", 32'(q.size()), 32'(0));
    check("drain_out_valid", 32'(out_valid), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
